// File: rtl/icache_ctrl.sv
// icache_ctrl: lookup/refill sequencer for a direct-mapped instruction cache with register tag/valid storage.
// Define ICACHE_INVALIDATE_EN to add the inv_all port (flash-clear of all valid bits from IDLE).
module icache_ctrl #(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 5
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ICACHE_INVALIDATE_EN
  input  logic        inv_all,
`endif
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        dram_en,
  output logic [3:0]  dram_wen,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_rdy,
  input  logic        mem_ret_valid,
  input  logic        mem_ret_last,
  input  logic [31:0] mem_ret_data
);
  localparam int WORD_W = OFFSET_W - 2;
  localparam int LINES  = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MISS   = 3'd2,
    REFILL = 3'd3,
    RESP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic               tag_we;
  logic [WORD_W-1:0]  cnt_q, cnt_d;
  logic [31:0]        resp_q, resp_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [INDEX_W-1:0] req_idx;
  logic [WORD_W-1:0]  req_word;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               inv_req;
  logic               unused_addr_bits;

  function automatic logic [31:0] ram_word_addr(input logic [INDEX_W-1:0] idx,
                                                input logic [WORD_W-1:0]  word);
    return {{(32-INDEX_W-WORD_W){1'b0}}, idx, word};
  endfunction

`ifdef ICACHE_INVALIDATE_EN
  assign inv_req = inv_all;
`else
  assign inv_req = 1'b0;
`endif

  assign req_idx          = req_addr_q[OFFSET_W +: INDEX_W];
  assign req_word         = req_addr_q[2 +: WORD_W];
  assign req_tag          = req_addr_q[31 -: TAG_W];
  assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr_bits = ^req_addr_q[1:0];

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_addr_q <= 32'h0000_0000;
      valid_q    <= {LINES{1'b0}};
      cnt_q      <= {WORD_W{1'b0}};
      resp_q     <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

  // Tag array: written only when a refill completes; contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (rst && tag_we) begin
      tag_q[req_idx] <= req_tag;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    tag_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (inv_req) begin
          valid_d = {LINES{1'b0}};
        end else if (cpu_req) begin
          req_addr_d = cpu_addr;
          state_d    = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (hit) begin
          rdata_d = dram_rdata;
          state_d = IDLE;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        if (mem_rd_rdy) begin
          cnt_d   = {WORD_W{1'b0}};
          state_d = REFILL;
        end else begin
          state_d = MISS;
        end
      end
      REFILL: begin
        if (mem_ret_valid) begin
          cnt_d = cnt_q + {{(WORD_W-1){1'b0}}, 1'b1};
          if (cnt_q == req_word) begin
            resp_d = mem_ret_data;
          end else begin
            resp_d = resp_q;
          end
          // A short burst still marks the line valid; upstream guarantees full bursts
          if (mem_ret_last) begin
            valid_d[req_idx] = 1'b1;
            tag_we           = 1'b1;
            state_d          = RESP;
          end else begin
            state_d = REFILL;
          end
        end else begin
          state_d = REFILL;
        end
      end
      RESP: begin
        rdata_d = resp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything is quiet while reset is asserted
  always_comb begin
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = rdata_q;
    dram_en     = 1'b0;
    dram_wen    = 4'h0;
    dram_addr   = 32'h0000_0000;
    dram_wdata  = 32'h0000_0000;
    mem_rd_req  = 1'b0;
    mem_rd_addr = 32'h0000_0000;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (cpu_req && !inv_req) begin
            cpu_addr_ok = 1'b1;
            dram_en     = 1'b1;
            dram_addr   = ram_word_addr(cpu_addr[OFFSET_W +: INDEX_W], cpu_addr[2 +: WORD_W]);
          end else begin
            cpu_addr_ok = 1'b0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_data_ok = 1'b1;
            cpu_rdata   = dram_rdata;
          end else begin
            cpu_data_ok = 1'b0;
          end
        end
        MISS: begin
          mem_rd_req  = 1'b1;
          mem_rd_addr = {req_addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
        end
        REFILL: begin
          if (mem_ret_valid) begin
            dram_en    = 1'b1;
            dram_wen   = 4'hF;
            dram_addr  = ram_word_addr(req_idx, cnt_q);
            dram_wdata = mem_ret_data;
          end else begin
            dram_en = 1'b0;
          end
        end
        RESP: begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = resp_q;
        end
        default: cpu_data_ok = 1'b0;
      endcase
    end else begin
      cpu_addr_ok = 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: scoreboard bench for icache_ctrl with a behavioural cache model and a data RAM / burst memory responder.
module tb_icache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
`ifdef ICACHE_INVALIDATE_EN
  logic        inv_all = 1'b0;
`endif
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        dram_en;
  logic [3:0]  dram_wen;
  logic [31:0] dram_addr, dram_wdata;
  logic [31:0] dram_rdata = 32'h0;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_rdy = 1'b0;
  logic        mem_ret_valid = 1'b0;
  logic        mem_ret_last = 1'b0;
  logic [31:0] mem_ret_data = 32'h0;

  icache_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef ICACHE_INVALIDATE_EN
    .inv_all(inv_all),
`endif
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .dram_en(dram_en), .dram_wen(dram_wen), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
    .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          hit;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          chk_en = 1'b0;
  bit          cur_miss = 1'b0;
  logic [31:0] cur_line = 32'h0;
  logic [31:0] last_rdata = 32'h0;
  bit          m_valid [128];
  logic [19:0] m_tag [128];
  logic [31:0] ram [1024];

  // Backing memory contents: every word address gets a unique value (line 0x1000 holds 0x11..0x18)
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a - 32'h0000_1000) >> 2) + 32'h0000_0011;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // External single-port data RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (dram_en) begin
      if (dram_wen == 4'hF) ram[dram_addr[9:0]] <= dram_wdata;
      else dram_rdata <= ram[dram_addr[9:0]];
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents data
  always @(negedge clk) begin
    if (chk_en) begin
      if (cpu_data_ok) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_data_ok", 72'd1, 72'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rdata", 72'(cpu_rdata), 72'(e.data));
          if (e.hit) chk("hit_latency", 72'(cyc - acc_cyc), 72'd1);
          else chk("miss_latency_min", 72'((cyc - acc_cyc) >= 12), 72'd1);
          last_rdata = e.data;
        end
      end else begin
        chk("rdata_hold", 72'(cpu_rdata), 72'(last_rdata));
      end
      if (mem_rd_req) chk("mem_rd_addr", 72'({cur_miss, mem_rd_addr}), 72'({1'b1, cur_line}));
    end
  end

  task automatic flush_req();
    cpu_req  = 1'b0;
    cur_miss = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_req(input logic [31:0] a, input int rdy_dly, input bit gapped,
                        input int rst_beat, input bit inv);
    exp_t        e;
    logic [6:0]  ix;
    logic [31:0] line;
    bit          hit;
    int          n;
    ix   = a[11:5];
    line = {a[31:5], 5'b0};
    if (inv) model_clear();
    hit    = m_valid[ix] && (m_tag[ix] == a[31:12]);
    e.data = mem_word(a);
    e.hit  = hit;
    exp_q.push_back(e);
    cur_line = line;
    cur_miss = !hit;
    if (!hit) begin
      m_valid[ix] = 1'b1;
      m_tag[ix]   = a[31:12];
    end
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_addr = a;
`ifdef ICACHE_INVALIDATE_EN
    if (inv) begin
      inv_all = 1'b1;
      @(negedge clk);
      chk("inv_blocks_accept", 72'(cpu_addr_ok), 72'd0);
      @(posedge clk); #1;
      inv_all = 1'b0;
    end
`endif
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_addr_ok && n < 20);
    chk("accept", 72'(cpu_addr_ok), 72'd1);
    if (!cpu_addr_ok) begin flush_req(); return; end
    acc_cyc = cyc;
    @(posedge clk); #1;
    cpu_req  = 1'b0;
    cpu_addr = $urandom & 32'hFFFF_FFFC;
    if (!hit) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!mem_rd_req && n < 20);
      chk("mem_rd_req_seen", 72'(mem_rd_req), 72'd1);
      if (!mem_rd_req) begin flush_req(); return; end
      for (int i = 0; i < rdy_dly; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("mem_rd_req_held", 72'(mem_rd_req), 72'd1);
      end
      @(posedge clk); #1;
      mem_rd_rdy = 1'b1;
      @(posedge clk); #1;
      mem_rd_rdy = 1'b0;
      cur_miss   = 1'b0;
      for (int b = 0; b < 8; b++) begin
        int gaps;
        gaps = gapped ? int'($urandom_range(0, 2)) : 0;
        for (int g = 0; g < gaps; g++) begin
          mem_ret_valid = 1'b0;
          @(negedge clk);
          chk("gap_dram_idle", 72'(dram_en), 72'd0);
          @(posedge clk); #1;
        end
        mem_ret_valid = 1'b1;
        mem_ret_last  = (b == 7);
        mem_ret_data  = mem_word(line + 32'(b * 4));
        if (b == rst_beat) begin
          rst = 1'b0;
          @(posedge clk); #1;
          rst           = 1'b1;
          mem_ret_valid = 1'b0;
          mem_ret_last  = 1'b0;
          void'(exp_q.pop_back());
          model_clear();
          last_rdata = 32'h0;
          @(negedge clk);
          chk("reset_outputs", 72'({cpu_addr_ok, cpu_data_ok, dram_en, dram_wen, mem_rd_req, mem_rd_addr}), 72'd0);
          chk("reset_dram_bus", 72'({dram_addr, dram_wdata}), 72'd0);
          chk("reset_rdata", 72'(cpu_rdata), 72'd0);
          @(posedge clk); #1;
          mem_ret_valid = 1'b1;
          mem_ret_data  = 32'hDEAD_BEEF;
          @(negedge clk);
          chk("stray_beat_ignored", 72'({dram_en, dram_wen, cpu_data_ok}), 72'd0);
          @(posedge clk); #1;
          mem_ret_valid = 1'b0;
          return;
        end
        @(negedge clk);
        chk("refill_write", 72'({dram_en, dram_wen, dram_addr, dram_wdata}),
            72'({1'b1, 4'hF, 22'd0, ix, 3'(b), mem_ret_data}));
        @(posedge clk); #1;
      end
      mem_ret_valid = 1'b0;
      mem_ret_last  = 1'b0;
      @(negedge clk);
      chk("miss_resp_cycle", 72'(cpu_data_ok), 72'd1);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("response_seen", 72'(exp_q.size()), 72'd0);
    flush_req();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("init_outputs", 72'({cpu_addr_ok, cpu_data_ok, dram_en, dram_wen, mem_rd_req, mem_rd_addr}), 72'd0);
    chk("init_rdata", 72'(cpu_rdata), 72'd0);
    chk_en = 1'b1;

    do_req(32'h0000_1004, 0, 1'b0, -1, 1'b0);
    do_req(32'h0000_1004, 0, 1'b0, -1, 1'b0);
    do_req(32'h0000_101C, 0, 1'b0, -1, 1'b0);
    do_req(32'h0000_2004, 0, 1'b0, -1, 1'b0);
    do_req(32'h0000_1004, 0, 1'b0, -1, 1'b0);
    do_req(32'h0000_3008, 5, 1'b1, -1, 1'b0);
    do_req(32'h0000_4010, 0, 1'b0, 3, 1'b0);
    do_req(32'h0000_4010, 1, 1'b1, -1, 1'b0);
    do_req(32'h0000_4010, 0, 1'b0, -1, 1'b0);
`ifdef ICACHE_INVALIDATE_EN
    do_req(32'h0000_1004, 0, 1'b0, -1, 1'b0);
    do_req(32'h0000_1004, 0, 1'b0, -1, 1'b1);
`endif
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = {20'($urandom_range(1, 3)), 7'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      do_req(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Lookup/refill sequencer for the direct-mapped instruction cache.
- Owns tag and valid storage in registers.
- Drives the external single-port instruction data RAM: 32-bit words, 1-cycle read latency.
- Serves fetch requests through an addr_ok/data_ok handshake and refills 32-byte lines from a burst read port.

Parameters:
- TAG_W, 20, tag width (addr[31:12]).
- INDEX_W, 7, set index width (addr[11:5]); 128 lines.
- OFFSET_W, 5, line offset width; 8 words per line.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- cpu_req  in  1  fetch request.
- cpu_addr  in  32  fetch byte address, word-aligned.
- cpu_addr_ok  out  1  request accepted this cycle.
- cpu_data_ok  out  1  cpu_rdata valid, one-cycle pulse.
- cpu_rdata  out  32  fetched instruction.
- dram_en  out  1  data RAM enable.
- dram_wen  out  4  data RAM byte write enables.
- dram_addr  out  32  data RAM word address; {index, word} in low bits, upper bits 0.
- dram_wdata  out  32  data RAM write data.
- dram_rdata  in  32  data RAM read data, valid the cycle after a read.
- mem_rd_req  out  1  line read request.
- mem_rd_addr  out  32  line-aligned address.
- mem_rd_rdy  in  1  line read request accepted.
- mem_ret_valid  in  1  return beat valid.
- mem_ret_last  in  1  final return beat.
- mem_ret_data  in  32  return beat data.

Behaviour:
- States: IDLE, LOOKUP, MISS, REFILL, RESP.
- Reset while rst=0 at a rising edge, regardless of current state:
  - state=IDLE; all 128 valid bits=0; refill counter=0.
  - All outputs 0. An in-flight burst is abandoned; stray beats in IDLE are ignored.
- IDLE:
  - cpu_addr_ok = cpu_req (combinational).
  - On accept: latch cpu_addr; drive dram_en=1, dram_wen=0, dram_addr={addr[11:5],addr[4:2]}; go to LOOKUP.
- LOOKUP:
  - hit = valid[idx] && tag[idx]==req_addr[31:12].
  - Hit: cpu_data_ok=1, cpu_rdata=dram_rdata, return to IDLE. Hit latency is 1 cycle after addr_ok. No new accept this cycle.
  - Miss: go to MISS.
- MISS:
  - mem_rd_req=1, mem_rd_addr={req_addr[31:5],5'b0}, both held stable until mem_rd_rdy=1.
  - On rdy: go to REFILL, cnt=0.
- REFILL, on each mem_ret_valid:
  - dram_en=1, dram_wen=4'hF, dram_addr={idx,cnt}, dram_wdata=mem_ret_data; cnt increments, wrapping at 8.
  - Beat with cnt==req_addr[4:2] is captured into the response register.
  - mem_ret_last: write tag[idx], set valid[idx]=1, go to RESP.
  - ret_last earlier than beat 8: line is still marked valid; the upstream must not do this.
  - Cycles without ret_valid: dram_en=0.
- RESP: cpu_data_ok=1, cpu_rdata=captured word, go to IDLE.
- Miss penalty = 1 (LOOKUP) + request wait + beats + 1 (RESP).
- cpu_addr_ok=0 in every state except IDLE. cpu_rdata holds its last value when data_ok=0.
- A line refill replaces whatever valid line was at idx; no writeback is needed.

Optional Feature:
- Macro: ICACHE_INVALIDATE_EN.
- With it:
  - Extra input port inv_all (1 bit).
  - inv_all=1 in IDLE clears all valid bits in one cycle. cpu_addr_ok is forced to 0 that cycle and the request is accepted next cycle.
  - inv_all in other states is ignored.
- Without it: no port; valid bits clear only on reset.

Test Plan:
- Reset, then request 0x0000_1004:
  - Miss; mem_rd_req with addr 0x0000_1000.
  - Beats 0x11..0x18 write dram_addr idx 0x00, words 0..7.
  - data_ok with rdata 0x12.
- Repeat 0x0000_1004 and then 0x0000_101C:
  - Hits with data_ok exactly 1 cycle after addr_ok; rdata 0x12, then 0x18; no mem_rd_req.
- Request 0x0000_2004 (same index, tag 0x2):
  - Refill replaces the line; a later 0x0000_1004 misses again.
- mem_rd_rdy delayed 5 cycles with gapped ret_valid:
  - mem_rd_addr stays stable; dram_en only on beat cycles; correct word returned.
- rst=0 during REFILL at beat 3:
  - Next cycle state is IDLE and outputs are 0; the same address then misses again.
- With ICACHE_INVALIDATE_EN:
  - Pulse inv_all after filling line 0x00; the next 0x0000_1004 misses.
  - cpu_addr_ok is 0 in the inv_all cycle.
